hex_keypad_entry: RTL and testbench
===================================

Name: hex_keypad_entry

Overview:
Input-side counterpart of the board's seven-segment display path: scans a 4x4 hex keypad, debounces presses, encodes each key to a 4-bit nibble and shifts it into a 16-bit entry word. The entry word feeds the operand registers in place of the raw slide switches. Runs on the board clock; Row pins come straight from the keypad header.

Parameters:
SCAN_DIV, 50000, clock cycles each column is driven before rows are sampled (>=2)
DEBOUNCE, 4, consecutive identical samples required to accept a press or a release (>=1)

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset_n  input  1  synchronous reset, active-low
Row  input  4  keypad rows, active-low, pulled up, asynchronous to Clock
Clear  input  1  synchronous clear of Entry/Digit_count, active-high
Col  output  4  keypad column drive, active-low, exactly one bit low at all times
Key_code  output  4  code of last accepted key, held until next accept
Key_valid  output  1  one-cycle pulse on key accept
Entry  output  16  shift register of entered nibbles, newest in [3:0]
Digit_count  output  3  number of nibbles entered since clear, saturates at 4

Behaviour:
- One clock; reset is synchronous and active-low (Clock, Reset_n).
- Reset values: Col=4'b1110 (column 0), Key_code=0, Key_valid=0, Entry=0, Digit_count=0, state SCAN, divider=0, debounce count=0, synchronizer flops=4'b1111.
- Row passes through a 2-flop synchronizer; only the synchronized value is used.
- Divider counts 0..SCAN_DIV-1; the sample point is the cycle divider==SCAN_DIV-1. Col changes only in SCAN, on the cycle after a sample point.
- Valid pattern: exactly one synchronized row low. Zero or multiple rows low means no key.
- Key encoding: row r (bit index of low row), column c: code = {r[1:0], c[1:0]} = 4*r + c.
- FSM states:
  - SCAN: at a sample point with no key, advance the column (0->1->2->3->0, Col rotates the low bit left). With a valid pattern, latch the pattern, set count=1, freeze the column and go to DEBOUNCE (or ACCEPT directly if DEBOUNCE==1).
  - DEBOUNCE: at each sample point, a matching pattern increments count; at count==DEBOUNCE go to ACCEPT. A mismatch returns to SCAN with count=0 on the same column.
  - ACCEPT: single cycle. Key_valid=1, Key_code=latched code, Entry<={Entry[11:0],code}, Digit_count=min(Digit_count+1,4). Then go to HELD.
  - HELD: column frozen. At each sample point, all rows high increments the release count, any low row resets it to 0. At count==DEBOUNCE, return to SCAN on the same column.
- Latency: Key_valid asserts exactly 1 cycle after the DEBOUNCE-th matching sample point.
- Holding a key gives exactly one accept, with no auto-repeat.
- A fifth and later digit shifts the oldest nibble out of Entry[15:12]; Digit_count stays 4.
- Clear: Entry=0, Digit_count=0 next cycle. FSM, Key_code and Key_valid are unaffected.
  - Clear coincident with ACCEPT: Clear wins for Entry/Digit_count (both 0), Key_valid still pulses and Key_code updates.
- Reset_n low mid-operation (any state) restores all reset values next edge and discards any partially debounced key.

Decomposition:
- Shared package keypad_pkg: state enum (SCAN, DEBOUNCE, ACCEPT, HELD), DIGITS_MAX=4, COL_IDLE=4'b1110.
- One sub-module, keypad_row_sync: 2-flop synchronizer with reset value 4'b1111.
- Divider, FSM and entry register stay in the top module.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE=3.
- Reset: hold Reset_n=0 for 3 cycles with Row=4'b0000 -> Col=1110, Entry=0000, Key_valid=0, Digit_count=0.
- Clean press: drive Row[2]=0 only while Col=1101 (column 1) -> single Key_valid pulse 1 cycle after the 3rd matching sample, Key_code=9, Entry=0009, Col stays 1101 until the release is debounced.
- Entry shift: press keys 1,2,3,4 then F, releasing each -> Entry=1234 with Digit_count=4, then Entry=234F with Digit_count=4.
- Bounce: row low for 2 samples then high, then low again for 3 samples -> no pulse after the first attempt, exactly one pulse total.
- Multi-key: Row=4'b1100 in column 0 -> no Key_valid, columns keep rotating.
- Clear collision: assert Clear in the ACCEPT cycle of key 7 -> Key_valid=1, Key_code=7, next cycle Entry=0000 and Digit_count=0. Separately, Reset_n=0 during HELD -> returns to SCAN with Col=1110.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the hex keypad entry path.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_ACCEPT,
    ST_HELD
  } kp_state_e;

  localparam int         DIGITS_MAX = 4;
  localparam logic [3:0] COL_IDLE   = 4'b1110;

  // Column drive for a column index: the single low bit of COL_IDLE rotated left.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [7:0] dbl;
    dbl = {COL_IDLE, COL_IDLE} << idx;
    return dbl[7:4];
  endfunction

  // True when exactly one row is pulled low (a single, unambiguous key).
  function automatic logic row_single(input logic [3:0] row);
    return $countones(~row) == 1;
  endfunction

  // Bit index of the low row; only meaningful when row_single() holds.
  function automatic logic [1:0] row_index(input logic [3:0] row);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!row[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/hex_keypad_entry_if.sv
// Keypad pins and entry-word outputs bundled as one interface.
interface hex_keypad_entry_if;
  logic [3:0]  Row;
  logic        Clear;
  logic [3:0]  Col;
  logic [3:0]  Key_code;
  logic        Key_valid;
  logic [15:0] Entry;
  logic [2:0]  Digit_count;

  modport master (output Row, Clear,
                  input  Col, Key_code, Key_valid, Entry, Digit_count);
  modport slave  (input  Row, Clear,
                  output Col, Key_code, Key_valid, Entry, Digit_count);
endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row pins (idle = all high).
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_async,
  output logic [3:0] row_sync
);
  logic [3:0] s1_d, s1_q, s2_d, s2_q;

  // Shift the raw rows through two stages.
  always_comb begin
    s1_d = row_async;
    s2_d = s1_q;
  end

  // Synchronizer stages, reset to "no row pulled".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 4'hF;
      s2_q <= 4'hF;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign row_sync = s2_q;
endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner: column scan, press/release debounce, nibble entry shift.
module hex_keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input logic               Clock,
  input logic               Reset_n,
  hex_keypad_entry_if.slave kp
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_N     = CNT_W'(DEBOUNCE);

  logic [3:0] row_s;
  kp_state_e  state_d, state_q;
  logic [DIV_W-1:0] div_d, div_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, cnt_inc;
  logic [1:0]  col_idx_d, col_idx_q;
  logic [3:0]  pat_d, pat_q;
  logic [3:0]  key_code_d, key_code_q;
  logic        key_valid_d, key_valid_q;
  logic [15:0] entry_d, entry_q;
  logic [2:0]  digits_d, digits_q;
  logic        sample;

  keypad_row_sync u_sync (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .row_async (kp.Row),
    .row_sync  (row_s)
  );

  assign sample  = (div_q == DIV_LAST);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Free-running scan divider; its last count is the row sample point.
  always_comb begin
    div_d = sample ? '0 : div_q + DIV_W'(1);
  end

  // Scan/debounce FSM. The column is frozen from first detection until release.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    pat_d       = pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    unique case (state_q)
      ST_SCAN: if (sample) begin
        if (row_single(row_s)) begin
          pat_d = row_s;
          cnt_d = CNT_W'(1);
          if (DEBOUNCE == 1) begin
            state_d     = ST_ACCEPT;
            key_valid_d = 1'b1;
            key_code_d  = {row_index(row_s), col_idx_q};
          end else begin
            state_d = ST_DEBOUNCE;
          end
        end else begin
          col_idx_d = col_idx_q + 2'd1;
        end
      end
      ST_DEBOUNCE: if (sample) begin
        if (row_s == pat_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_N) begin
            state_d     = ST_ACCEPT;
            key_valid_d = 1'b1;
            key_code_d  = {row_index(pat_q), col_idx_q};
          end
        end else begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      end
      ST_ACCEPT: begin
        state_d = ST_HELD;
        cnt_d   = '0;
      end
      ST_HELD: if (sample) begin
        if (&row_s) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_N) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Entry shift register; Clear takes priority over a simultaneous accept.
  always_comb begin
    entry_d  = entry_q;
    digits_d = digits_q;
    if (kp.Clear) begin
      entry_d  = '0;
      digits_d = '0;
    end else if (state_q == ST_ACCEPT) begin
      entry_d = {entry_q[11:0], key_code_q};
      if (digits_q != 3'(DIGITS_MAX)) digits_d = digits_q + 3'd1;
    end
  end

  // State registers.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= ST_SCAN;
      div_q       <= '0;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      pat_q       <= 4'hF;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      entry_q     <= '0;
      digits_q    <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      pat_q       <= pat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      entry_q     <= entry_d;
      digits_q    <= digits_d;
    end
  end

  assign kp.Col         = col_drive(col_idx_q);
  assign kp.Key_code    = key_code_q;
  assign kp.Key_valid   = key_valid_q;
  assign kp.Entry       = entry_q;
  assign kp.Digit_count = digits_q;
endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: reactive keypad model, cycle model, directed presses.
module tb_hex_keypad_entry;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hex_keypad_entry_if kif ();

  hex_keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .kp      (kif)
  );

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  // Physical keypad: a pressed key shorts its row to the driven column.
  logic [15:0] key_mask;
  logic        row_force_en;
  logic [3:0]  row_force;
  logic [3:0]  row_drv;
  always_comb begin
    row_drv = 4'hF;
    if (row_force_en) row_drv = row_force;
    else
      for (int k = 0; k < 16; k++)
        if (key_mask[k] && kif.Col[k % 4] === 1'b0) row_drv[k / 4] = 1'b0;
  end
  assign kif.Row = row_drv;

  // Inputs as seen by the DUT at each rising edge.
  logic [3:0] snap_row;
  logic       snap_clr, snap_rstn;
  always @(posedge clk) begin
    snap_row  <= kif.Row;
    snap_clr  <= kif.Clear;
    snap_rstn <= rst_n;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: sample-point arithmetic, streak counters, entry as a word.
  bit          mv = 0;
  logic [3:0]  sp0, sp1;
  int          m_mod, m_col, m_streak, m_rel, m_cnt;
  logic [3:0]  m_cand, m_code;
  bit          m_deb, m_held, m_pulse;
  logic [15:0] m_entry;

  task automatic step_model();
    int   zeros, r;
    bit   samp, np;
    logic [3:0] sy;
    if (!snap_rstn) begin
      sp0 = 4'hF; sp1 = 4'hF; m_mod = 0; m_col = 0; m_streak = 0; m_rel = 0;
      m_cnt = 0; m_cand = 4'hF; m_code = 4'h0; m_deb = 0; m_held = 0;
      m_pulse = 0; m_entry = 16'h0; mv = 1;
      return;
    end
    sy = sp1; sp1 = sp0; sp0 = snap_row;
    samp = (m_mod == SCAN_DIV - 1);
    m_mod = (m_mod + 1) % SCAN_DIV;
    if (snap_clr) begin
      m_entry = 16'h0; m_cnt = 0;
    end else if (m_pulse) begin
      m_entry = {m_entry[11:0], m_code};
      if (m_cnt < 4) m_cnt++;
    end
    np = 0;
    if (m_pulse) begin
      m_held = 1; m_rel = 0;
    end else if (m_held) begin
      if (samp) begin
        if (sy == 4'hF) m_rel++; else m_rel = 0;
        if (m_rel == DEBOUNCE) begin m_held = 0; m_rel = 0; end
      end
    end else if (m_deb) begin
      if (samp) begin
        if (sy == m_cand) begin
          m_streak++;
          if (m_streak == DEBOUNCE) begin
            m_deb = 0; np = 1; r = 0;
            for (int i = 0; i < 4; i++) if (!m_cand[i]) r = i;
            m_code = 4'(4 * r + m_col);
          end
        end else begin
          m_deb = 0; m_streak = 0;
        end
      end
    end else if (samp) begin
      zeros = 0;
      for (int i = 0; i < 4; i++) if (!sy[i]) zeros++;
      if (zeros == 1) begin m_cand = sy; m_streak = 1; m_deb = 1; end
      else m_col = (m_col + 1) % 4;
    end
    m_pulse = np;
  endtask

  // Compare process: every cycle after reset has been seen.
  initial begin
    forever begin
      @(negedge clk);
      step_model();
      if (mv) begin
        chk("Col",         16'(kif.Col),         16'(4'hF ^ (4'd1 << m_col)));
        chk("Key_valid",   16'(kif.Key_valid),   16'(m_pulse));
        chk("Key_code",    16'(kif.Key_code),    16'(m_code));
        chk("Entry",       kif.Entry,            m_entry);
        chk("Digit_count", 16'(kif.Digit_count), 16'(m_cnt));
      end
      if (kif.Key_valid === 1'b1) pulse_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Press key k, wait for its accept, release and let the release debounce.
  task automatic press_key(input int k, input string nm);
    int p0;
    bit got;
    p0 = pulse_cnt;
    got = 0;
    key_mask = 16'(1) << k;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      if (pulse_cnt != p0) got = 1;
    end
    chk({nm, "_accepted"}, 16'(got), 16'd1);
    key_mask = '0;
    repeat (40) tick();
    chk({nm, "_one_pulse"}, 16'(pulse_cnt - p0), 16'd1);
  endtask

  initial begin
    int   p0;
    bit   got;
    logic [3:0] seen;
    rst_n = 1'b0;
    kif.Clear = 1'b0;
    key_mask = '0;
    row_force_en = 1'b1;
    row_force = 4'b0000;
    repeat (3) tick();
    chk("rst_Col",       16'(kif.Col),         16'h000E);
    chk("rst_Entry",     kif.Entry,            16'h0000);
    chk("rst_Key_valid", 16'(kif.Key_valid),   16'h0000);
    chk("rst_Digits",    16'(kif.Digit_count), 16'h0000);
    rst_n = 1'b1;
    row_force_en = 1'b0;
    repeat (5) tick();

    // Clean press of key 9 (row 2, column 1).
    key_mask = 16'(1) << 9;
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      if (kif.Key_valid === 1'b1) got = 1;
    end
    chk("k9_pulse",    16'(got),          16'd1);
    chk("k9_code",     16'(kif.Key_code), 16'h0009);
    chk("k9_col_held", 16'(kif.Col),      16'h000D);
    repeat (6) tick();
    chk("k9_col_frozen", 16'(kif.Col), 16'h000D);
    key_mask = '0;
    repeat (40) tick();
    chk("k9_entry",  kif.Entry,            16'h0009);
    chk("k9_digits", 16'(kif.Digit_count), 16'd1);

    // Entry shift with saturation.
    press_key(1, "k1");
    press_key(2, "k2");
    press_key(3, "k3");
    press_key(4, "k4");
    chk("shift_1234",    kif.Entry,            16'h1234);
    chk("shift_digits4", 16'(kif.Digit_count), 16'd4);
    press_key(15, "kF");
    chk("shift_234F",    kif.Entry,            16'h234F);
    chk("shift_sat4",    16'(kif.Digit_count), 16'd4);

    // Bounce: release after two matching samples, then a real press.
    p0 = pulse_cnt;
    key_mask = 16'(1) << 6;
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      if (m_deb && m_streak == 2) got = 1;
    end
    chk("bounce_reached2", 16'(got), 16'd1);
    key_mask = '0;
    repeat (16) tick();
    chk("bounce_no_pulse", 16'(pulse_cnt - p0), 16'd0);
    press_key(6, "k6");
    chk("bounce_total", 16'(pulse_cnt - p0), 16'd1);

    // Two rows low in column 0: never a key, scan keeps rotating.
    p0 = pulse_cnt;
    key_mask = 16'h0011;
    seen = 4'h0;
    repeat (48) begin
      tick();
      seen = seen | ~kif.Col;
    end
    key_mask = '0;
    chk("multi_no_pulse", 16'(pulse_cnt - p0), 16'd0);
    chk("multi_rotates",  16'(seen),           16'h000F);
    repeat (8) tick();

    // Clear landing in the accept cycle of key 7.
    key_mask = 16'(1) << 7;
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      if (kif.Key_valid === 1'b1) got = 1;
    end
    chk("clr_pulse", 16'(kif.Key_valid), 16'd1);
    chk("clr_code",  16'(kif.Key_code),  16'h0007);
    kif.Clear = 1'b1;
    tick();
    kif.Clear = 1'b0;
    chk("clr_entry",  kif.Entry,            16'h0000);
    chk("clr_digits", 16'(kif.Digit_count), 16'd0);
    key_mask = '0;
    repeat (40) tick();

    // Reset while a key is held.
    press_key(9, "k9b");
    key_mask = 16'(1) << 9;
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      if (kif.Key_valid === 1'b1) got = 1;
    end
    chk("held_pulse", 16'(got), 16'd1);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("held_rst_col",   16'(kif.Col),       16'h000E);
    chk("held_rst_entry", kif.Entry,          16'h0000);
    chk("held_rst_valid", 16'(kif.Key_valid), 16'd0);
    key_mask = '0;
    rst_n = 1'b1;
    p0 = pulse_cnt;
    repeat (40) tick();
    chk("held_rst_quiet", 16'(pulse_cnt - p0), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
